rr_mux_nto1: RTL

Parametrised N-to-1 multiplexer with per-channel valid/ready handshakes, a registered output stage and two selection modes: round-robin arbitration or a fixed external select. It is the next generation of the team's combinational 2:1 mux. It adds width, channel-count and mode parameters, plus flow control, so that several producers can share one downstream consumer without dropping or duplicating words.

---
 rtl/rr_mux_nto1_pkg.sv | 32 +++
 rtl/rr_mux_nto1_arbiter.sv | 32 +++
 rtl/rr_mux_nto1.sv | 83 ++++++++
 3 files changed

// File: rtl/rr_mux_nto1_pkg.sv
// rtl/rr_mux_nto1_pkg.sv - shared helpers for the round-robin mux and other arbiters
package rr_mux_nto1_pkg;

   // Widest request vector the shared pick function handles.
   localparam int unsigned MAX_CH = 32;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // First set request at or above ptr, wrapping at n; returns a one-hot (or zero) grant.
   function automatic logic [MAX_CH-1:0] rr_pick(
      input logic [MAX_CH-1:0] req,
      input int unsigned       ptr,
      input int unsigned       n
   );
      logic [MAX_CH-1:0] grant;
      logic              found;
      int unsigned       idx;
      grant = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < MAX_CH; k++) begin
         idx = (ptr + k) % n;
         if (k < n && !found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/rr_mux_nto1_arbiter.sv
// rtl/rr_mux_nto1_arbiter.sv - combinational round-robin arbiter with one-hot and index grant
module rr_arbiter
   import rr_mux_nto1_pkg::*;
#(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned SEL_W = 2
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_CH-1:0]  grant,
   output logic [SEL_W-1:0] grant_idx
);

   function automatic logic [N_CH-1:0] pick(
      input logic [N_CH-1:0]  r,
      input logic [SEL_W-1:0] p
   );
      logic [MAX_CH-1:0] full;
      full = rr_pick(MAX_CH'(r), 32'(p), N_CH);
      return full[N_CH-1:0];
   endfunction

   assign grant = pick(req, ptr);

   always_comb begin
      grant_idx = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (grant[i]) grant_idx = SEL_W'(i);
      end
   end

endmodule

// File: rtl/rr_mux_nto1.sv
// rtl/rr_mux_nto1.sv - N-to-1 valid/ready mux, round-robin or fixed select, registered output
module rr_mux_nto1
   import rr_mux_nto1_pkg::*;
#(
   parameter  int unsigned N_CH   = 4,
   parameter  int unsigned DATA_W = 8,
   localparam int unsigned SEL_W  = sel_width(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_CH-1:0]        in_valid,
   input  logic [N_CH*DATA_W-1:0] in_data,
   output logic [N_CH-1:0]        in_ready,
   input  logic                   mode,
   input  logic [SEL_W-1:0]       sel,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic [SEL_W-1:0]       out_ch,
   input  logic                   out_ready
);

   logic [SEL_W-1:0]  ptr;
   logic [SEL_W-1:0]  ptr_next;
   logic [SEL_W-1:0]  rr_idx;
   logic [SEL_W-1:0]  grant_idx;
   logic [N_CH-1:0]   rr_grant;
   logic [N_CH-1:0]   fixed_grant;
   logic [N_CH-1:0]   grant;
   logic [DATA_W-1:0] grant_data;
   logic              free;
   logic              xfer;

   rr_arbiter #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_arb (
      .req       (in_valid),
      .ptr       (ptr),
      .grant     (rr_grant),
      .grant_idx (rr_idx)
   );

   // An out-of-range sel matches no channel, so it naturally yields no grant.
   always_comb begin
      fixed_grant = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         fixed_grant[i] = in_valid[i] && (sel == SEL_W'(i));
      end
   end

   assign grant     = mode ? fixed_grant : rr_grant;
   assign grant_idx = mode ? sel : rr_idx;
   assign free      = !out_valid || out_ready;
   assign in_ready  = free ? grant : '0;
   assign xfer      = |(in_valid & in_ready);
   assign ptr_next  = (rr_idx == SEL_W'(N_CH - 1)) ? '0 : rr_idx + 1'b1;

   always_comb begin
      grant_data = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (grant[i]) grant_data = in_data[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
      end else if (free) begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant_idx;
            if (!mode) ptr <= ptr_next;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
